// File: rtl/multi_div_pkg.sv
// Shared constants and helpers for the multi-rate clock divider.
package multi_div_pkg;

    localparam int unsigned DEF_NCH   = 4;
    localparam int unsigned DEF_CNT_W = 8;
    localparam logic [DEF_NCH*DEF_CNT_W-1:0] DEF_DIVS = {8'd5, 8'd4, 8'd3, 8'd2};

    // Ceiling log2, usable in parameter expressions; clog2(1) returns 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = 32'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/multi_div_sel_sync2.sv
// Two-flop synchronizer for asynchronous level inputs (switches).
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two back-to-back flops give metastability a full clock to settle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/multi_div_sel.sv
// Multi-rate clock divider with glitch-free runtime rate select.
// A single counter produces a square wave whose half-period is DIVS[cur_sel];
// requested rate changes are applied only at a half-period boundary.
// Optional macro DIV_RUN_GATE_EN adds a 'run' input that freezes the divider.
module multi_div_sel
    import multi_div_pkg::*;
#(
    parameter  int unsigned             NCH   = DEF_NCH,
    parameter  int unsigned             CNT_W = DEF_CNT_W,
    parameter  logic [NCH*CNT_W-1:0]    DIVS  = DEF_DIVS,
    localparam int unsigned             SEL_W = clog2(NCH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [SEL_W-1:0] sel,
`ifdef DIV_RUN_GATE_EN
    input  logic             run,
`endif
    output logic             out,
    output logic             tick,
    output logic [SEL_W-1:0] cur_sel,
    output logic             pending
);

    localparam int unsigned NSLOT = 32'd1 << SEL_W;

    logic [SEL_W-1:0] sel_s;
    logic             run_s;
    logic [CNT_W-1:0] div_tab [NSLOT];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] half;
    logic             sel_ok;
    logic             req;
    logic             terminal;
    logic             out_nxt;
    logic             tick_nxt;
    logic             pend_nxt;
    logic [SEL_W-1:0] cur_nxt;

    sync2 #(.W(SEL_W)) u_sel_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (sel),
        .q       (sel_s)
    );

`ifdef DIV_RUN_GATE_EN
    sync2 #(.W(1)) u_run_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (run),
        .q       (run_s)
    );
`else
    assign run_s = 1'b1;
`endif

    // Divisor table padded to a power of two; unused slots never get selected.
    for (genvar i = 0; i < int'(NSLOT); i++) begin : g_tab
        if (i < int'(NCH)) begin : g_used
            assign div_tab[i] = DIVS[i*CNT_W +: CNT_W];
        end else begin : g_pad
            assign div_tab[i] = CNT_W'(1);
        end
    end

    // Next-state: count to H-1, toggle and pulse tick, switch rate on the boundary.
    always_comb begin
        half     = div_tab[cur_sel];
        sel_ok   = (32'(sel_s) < NCH);
        req      = sel_ok && (sel_s != cur_sel);
        cnt_nxt  = cnt;
        out_nxt  = out;
        tick_nxt = 1'b0;
        cur_nxt  = cur_sel;
        pend_nxt = req;
        if (half == '0) half = CNT_W'(1);
        terminal = (cnt == half - CNT_W'(1));
        if (run_s) begin
            if (terminal) begin
                cnt_nxt  = '0;
                out_nxt  = ~out;
                tick_nxt = 1'b1;
                if (req) cur_nxt = sel_s;
            end else begin
                cnt_nxt  = cnt + CNT_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            out     <= 1'b0;
            tick    <= 1'b0;
            cur_sel <= '0;
            pending <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            out     <= out_nxt;
            tick    <= tick_nxt;
            cur_sel <= cur_nxt;
            pending <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_multi_div_sel.sv
// Self-checking bench for multi_div_sel: default 4-rate instance and a 3-rate
// instance (out-of-range select), compared every clock against a rule model.
module tb_multi_div_sel;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [1:0] sel_a, sel_b;
    logic       out_a, tick_a, pend_a;
    logic       out_b, tick_b, pend_b;
    logic [1:0] cur_a, cur_b;
`ifdef DIV_RUN_GATE_EN
    logic       run;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    multi_div_sel dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .sel     (sel_a),
`ifdef DIV_RUN_GATE_EN
        .run     (run),
`endif
        .out     (out_a),
        .tick    (tick_a),
        .cur_sel (cur_a),
        .pending (pend_a)
    );

    multi_div_sel #(.NCH(3), .CNT_W(8), .DIVS(24'h04_03_02)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .sel     (sel_b),
`ifdef DIV_RUN_GATE_EN
        .run     (run),
`endif
        .out     (out_b),
        .tick    (tick_b),
        .cur_sel (cur_b),
        .pending (pend_b)
    );

    // Behavioural model state, index 0 = dut_a, 1 = dut_b.
    int divs [2][4] = '{'{2, 3, 4, 5}, '{2, 3, 4, 0}};
    int nch  [2]    = '{4, 3};
    int m_s1[2], m_s2[2], m_cnt[2], m_out[2], m_tick[2], m_cur[2], m_pend[2];
    int m_r1, m_r2;

    // Half-period measurement on dut_a's output.
    int since_a, last_half_a, min_half_a, max_half_a, ticks_a;
    logic prev_out_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s1[k] = 0; m_s2[k] = 0; m_cnt[k] = 0; m_out[k] = 0;
            m_tick[k] = 0; m_cur[k] = 0; m_pend[k] = 0;
        end
        m_r1 = 0; m_r2 = 0;
        since_a = 0; last_half_a = 0; min_half_a = 1000; max_half_a = 0;
        prev_out_a = 1'b0;
    endtask

    // One rising edge worth of the divider rules.
    task automatic model_edge();
        int  h, selv;
        bit  req, go;
        go = 1'b1;
`ifdef DIV_RUN_GATE_EN
        go = (m_r2 != 0);
`endif
        for (int k = 0; k < 2; k++) begin
            selv = (k == 0) ? int'(sel_a) : int'(sel_b);
            h    = divs[k][m_cur[k]];
            if (h == 0) h = 1;
            req  = (m_s2[k] < nch[k]) && (m_s2[k] != m_cur[k]);
            m_pend[k] = req ? 1 : 0;
            m_tick[k] = 0;
            if (go) begin
                if (m_cnt[k] == h - 1) begin
                    m_cnt[k]  = 0;
                    m_out[k]  = 1 - m_out[k];
                    m_tick[k] = 1;
                    if (req) m_cur[k] = m_s2[k];
                end else begin
                    m_cnt[k]++;
                end
            end
            m_s2[k] = m_s1[k];
            m_s1[k] = selv;
        end
`ifdef DIV_RUN_GATE_EN
        m_r2 = m_r1;
        m_r1 = run ? 1 : 0;
`endif
    endtask

    task automatic cmp_all();
        chk("a_out",  32'(out_a),  32'(m_out[0]));
        chk("a_tick", 32'(tick_a), 32'(m_tick[0]));
        chk("a_cur",  32'(cur_a),  32'(m_cur[0]));
        chk("a_pend", 32'(pend_a), 32'(m_pend[0]));
        chk("b_out",  32'(out_b),  32'(m_out[1]));
        chk("b_tick", 32'(tick_b), 32'(m_tick[1]));
        chk("b_cur",  32'(cur_b),  32'(m_cur[1]));
        chk("b_pend", 32'(pend_b), 32'(m_pend[1]));
    endtask

    // Advance one clock, update the model, sample 1 time unit after the edge.
    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        cmp_all();
        since_a++;
        if (tick_a === 1'b1) ticks_a++;
        if (out_a !== prev_out_a) begin
            last_half_a = since_a;
            if (since_a < min_half_a) min_half_a = since_a;
            if (since_a > max_half_a) max_half_a = since_a;
            since_a = 0;
            prev_out_a = out_a;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        sel_a   = 2'd0;
        sel_b   = 2'd0;
`ifdef DIV_RUN_GATE_EN
        run     = 1'b1;
`endif
        model_reset();
        #12;
        cmp_all();
        @(negedge clock);
        reset_n = 1'b1;
`ifdef DIV_RUN_GATE_EN
        // Let the run synchronizer fill before checking the free-running rate.
        m_r1 = 0; m_r2 = 0;
`endif

        // ch0 held: toggle every 2 clocks, tick every 2nd clock.
        ticks_a = 0;
`ifdef DIV_RUN_GATE_EN
        repeat (2) cyc();
        ticks_a = 0;
`endif
        repeat (12) cyc();
        chk("ch0_half", 32'(last_half_a), 32'd2);
        chk("ch0_ticks", 32'(ticks_a), 32'd6);
        chk("ch0_cur", 32'(cur_a), 32'd0);

        // 0 -> 3 mid half-period; dut_b gets out-of-range 3.
        for (int g = 0; g < 10 && m_cnt[0] != 0; g++) cyc();
        sel_a = 2'd3;
        sel_b = 2'd3;
        cyc(); chk("sw_pend_c1", 32'(pend_a), 32'd0);
        cyc(); chk("sw_pend_c2", 32'(pend_a), 32'd0);
        cyc(); chk("sw_pend_c3", 32'(pend_a), 32'd1);
        chk("sw_cur_before", 32'(cur_a), 32'd0);
        repeat (30) cyc();
        chk("sw_cur_after", 32'(cur_a), 32'd3);
        chk("sw_half5", 32'(last_half_a), 32'd5);
        chk("sw_min_half", 32'(min_half_a >= 2), 32'd1);
        chk("oor_pend", 32'(pend_b), 32'd0);
        chk("oor_cur", 32'(cur_b), 32'd0);

        // Move to ch1, then pulse a request for ch2 for one clock.
        sel_a = 2'd1;
        repeat (20) cyc();
        chk("ch1_cur", 32'(cur_a), 32'd1);
        for (int g = 0; g < 10 && m_cnt[0] != 1; g++) cyc();
        sel_a = 2'd2;
        cyc();
        sel_a = 2'd1;
        repeat (12) cyc();
        chk("pulse_cur", 32'(cur_a), 32'd1);
        chk("pulse_half", 32'(last_half_a), 32'd3);

        // ch2, then reset asserted in the middle of a half-period.
        sel_a = 2'd2;
        repeat (30) cyc();
        chk("ch2_half", 32'(last_half_a), 32'd4);
        for (int g = 0; g < 10 && m_cnt[0] != 2; g++) cyc();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out", 32'(out_a), 32'd0);
        chk("rst_tick", 32'(tick_a), 32'd0);
        chk("rst_cur", 32'(cur_a), 32'd0);
        chk("rst_pend", 32'(pend_a), 32'd0);
        sel_a = 2'd0;
        sel_b = 2'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
`ifdef DIV_RUN_GATE_EN
        repeat (2) cyc();
`endif
        repeat (10) cyc();
        chk("rst_restart_half", 32'(last_half_a), 32'd2);
        chk("rst_restart_cur", 32'(cur_a), 32'd0);

        // Random rate requests on both instances.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) sel_a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) sel_b = 2'($urandom_range(0, 3));
            cyc();
        end
        chk("rand_min_half", 32'(min_half_a >= 2), 32'd1);
        chk("rand_max_half", 32'(max_half_a <= 5), 32'd1);

`ifdef DIV_RUN_GATE_EN
        // Freeze on ch1 for 10 clocks, then resume.
        begin
            logic held;
            sel_a = 2'd1;
            sel_b = 2'd1;
            repeat (20) cyc();
            for (int g = 0; g < 10 && m_cnt[0] != 1; g++) cyc();
            run = 1'b0;
            repeat (2) cyc();
            held = out_a;
            repeat (10) begin
                cyc();
                chk("frz_out", 32'(out_a), 32'(held));
                chk("frz_tick", 32'(tick_a), 32'd0);
            end
            run = 1'b1;
            repeat (20) cyc();
            chk("resume_half", 32'(last_half_a), 32'd3);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
